// File: rtl/uart_fifo_core.sv
// UART with TX/RX serialisers, RX and TX FIFOs and a pending-data interrupt.
// Define UART_PARITY_EN to add an even-parity bit to every frame.
module uart_fifo_core #(
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          clk_freq,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_rd,
    output logic                 rx_avail,
    output logic                 rx_overrun,
    output logic                 frame_err,
    output logic                 parity_err,
    input  logic                 err_clr,
    output logic                 int_req
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

    logic [31:0] div_raw;
    logic [31:0] div_calc;

    assign div_raw  = clk_freq / 32'(BAUD_RATE);
    assign div_calc = (div_raw < 32'd2) ? 32'd2 : div_raw;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] txf_mem [FIFO_DEPTH];
    logic [AW:0]          txf_wp;
    logic [AW:0]          txf_rp;
    logic                 txf_empty;
    logic                 txf_push;
    logic                 txf_pop;
    logic [DATA_BITS-1:0] txf_head;

    assign txf_empty = (txf_wp == txf_rp);
    assign tx_full   = (txf_wp[AW] != txf_rp[AW]) &&
                       (txf_wp[AW-1:0] == txf_rp[AW-1:0]);
    assign txf_push  = tx_wr && !tx_full;
    assign txf_head  = txf_mem[txf_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (txf_push)
            txf_mem[txf_wp[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txf_wp <= '0;
            txf_rp <= '0;
        end else begin
            if (txf_push)
                txf_wp <= txf_wp + 1'b1;
            if (txf_pop)
                txf_rp <= txf_rp + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    logic [2:0]           tx_st;
    logic [31:0]          tx_div;
    logic [31:0]          tx_cnt;
    logic [DATA_BITS-1:0] tx_sh;
    logic [3:0]           tx_bit;
    logic [1:0]           tx_stop;
    logic                 tx_last;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    // Final stop bit ends this cycle: a queued word starts with no idle gap.
    assign tx_last = (tx_st == S_STOP) && (tx_cnt == 32'd0) &&
                     (tx_stop == LAST_STOP);
    assign txf_pop = ((tx_st == S_IDLE) || tx_last) && !txf_empty;
    assign tx_busy = (tx_st != S_IDLE) || !txf_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_st   <= S_IDLE;
            tx_div  <= 32'd2;
            tx_cnt  <= '0;
            tx_sh   <= '0;
            tx_bit  <= '0;
            tx_stop <= '0;
`ifdef UART_PARITY_EN
            tx_par  <= 1'b0;
`endif
        end else if (txf_pop) begin
            tx_st   <= S_START;
            tx_div  <= div_calc;
            tx_cnt  <= div_calc - 32'd1;
            tx_sh   <= txf_head;
`ifdef UART_PARITY_EN
            tx_par  <= ^txf_head;
`endif
        end else if (tx_st != S_IDLE) begin
            if (tx_cnt != 32'd0) begin
                tx_cnt <= tx_cnt - 32'd1;
            end else begin
                tx_cnt <= tx_div - 32'd1;
                case (tx_st)
                    S_START: begin
                        tx_st  <= S_DATA;
                        tx_bit <= '0;
                    end
                    S_DATA: begin
                        if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_st <= S_PARITY;
`else
                            tx_st <= S_STOP;
`endif
                            tx_stop <= '0;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            tx_sh  <= tx_sh >> 1;
                        end
                    end
                    S_PARITY: begin
                        tx_st   <= S_STOP;
                        tx_stop <= '0;
                    end
                    S_STOP: begin
                        if (tx_stop == LAST_STOP)
                            tx_st <= S_IDLE;
                        else
                            tx_stop <= tx_stop + 2'd1;
                    end
                    default: tx_st <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (tx_st)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_sh[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx = tx_par;
`else
            S_PARITY: tx = 1'b1;
`endif
            default:  tx = 1'b1;
        endcase
    end

    // ---------------- RX FSM ----------------
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic [2:0]           rx_st;
    logic [31:0]          rx_div;
    logic [31:0]          rx_cnt;
    logic [DATA_BITS-1:0] rx_sh;
    logic [3:0]           rx_bit;
    logic                 rx_push;
    logic                 fe_set;

    assign rx_push = (rx_st == S_STOP) && (rx_cnt == 32'd0);
    assign fe_set  = rx_push && !rx_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_st  <= S_IDLE;
            rx_div <= 32'd2;
            rx_cnt <= '0;
            rx_sh  <= '0;
            rx_bit <= '0;
        end else if (rx_st == S_IDLE) begin
            if (rx_prev && !rx_s2) begin
                rx_st  <= S_START;
                rx_div <= div_calc;
                rx_cnt <= (div_calc >> 1) - 32'd1;
            end
        end else if (rx_cnt != 32'd0) begin
            rx_cnt <= rx_cnt - 32'd1;
        end else begin
            rx_cnt <= rx_div - 32'd1;
            case (rx_st)
                S_START: begin
                    rx_st  <= rx_s2 ? S_IDLE : S_DATA;
                    rx_bit <= '0;
                end
                S_DATA: begin
                    rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                    if (rx_bit == LAST_BIT)
`ifdef UART_PARITY_EN
                        rx_st <= S_PARITY;
`else
                        rx_st <= S_STOP;
`endif
                    else
                        rx_bit <= rx_bit + 4'd1;
                end
                S_PARITY: rx_st <= S_STOP;
                S_STOP:   rx_st <= S_IDLE;
                default:  rx_st <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rxf_mem [FIFO_DEPTH];
    logic [AW:0]          rxf_wp;
    logic [AW:0]          rxf_rp;
    logic                 rxf_full;
    logic                 rxf_pop;
    logic                 rxf_push;
    logic                 ovr_set;

    assign rx_avail = (rxf_wp != rxf_rp);
    assign rxf_full = (rxf_wp[AW] != rxf_rp[AW]) &&
                      (rxf_wp[AW-1:0] == rxf_rp[AW-1:0]);
    assign rxf_pop  = rx_rd && rx_avail;
    assign rxf_push = rx_push && (!rxf_full || rxf_pop);
    assign ovr_set  = rx_push && rxf_full && !rxf_pop;
    assign rx_data  = rxf_mem[rxf_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rxf_push)
            rxf_mem[rxf_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxf_wp <= '0;
            rxf_rp <= '0;
        end else begin
            if (rxf_push)
                rxf_wp <= rxf_wp + 1'b1;
            if (rxf_pop)
                rxf_rp <= rxf_rp + 1'b1;
        end
    end

    // ---------------- Flags and interrupt ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            int_req    <= 1'b0;
        end else begin
            if (ovr_set)
                rx_overrun <= 1'b1;
            else if (err_clr)
                rx_overrun <= 1'b0;
            if (fe_set)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
            int_req <= rx_avail | rx_overrun;
        end
    end

`ifdef UART_PARITY_EN
    logic pe_set;
    logic pe_q;

    assign pe_set = (rx_st == S_PARITY) && (rx_cnt == 32'd0) &&
                    (rx_s2 != ^rx_sh);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pe_q <= 1'b0;
        else if (pe_set)
            pe_q <= 1'b1;
        else if (err_clr)
            pe_q <= 1'b0;
    end

    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: line timing, loopback, overrun,
// framing/glitch handling, parity and mid-frame reset.
module tb_uart_fifo_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] clk_freq;
    logic        rx;
    logic        tx;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_full;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_rd;
    logic        rx_avail;
    logic        rx_overrun;
    logic        frame_err;
    logic        parity_err;
    logic        err_clr;
    logic        int_req;

    logic        loop_en;
    logic        rx_drv;
    int          div;
    int          n_tests = 0;
    int          n_fail  = 0;
`ifdef UART_PARITY_EN
    logic        par_flip = 1'b0;
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_core dut (
        .clk        (clk),
        .reset      (rst),
        .clk_freq   (clk_freq),
        .rx         (rx),
        .tx         (tx),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_full    (tx_full),
        .tx_busy    (tx_busy),
        .rx_data    (rx_data),
        .rx_rd      (rx_rd),
        .rx_avail   (rx_avail),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .err_clr    (err_clr),
        .int_req    (int_req)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] w);
        int n = 0;
        while (tx_full && n < 5000) begin
            cyc(1);
            n++;
        end
        if (n == 5000)
            check("put_timeout", {31'd0, tx_full}, 32'd0);
        tx_data = w;
        tx_wr   = 1'b1;
        cyc(1);
        tx_wr   = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        check({tag, "_avail"}, {31'd0, rx_avail}, 32'd1);
        check(tag, {24'd0, rx_data}, {24'd0, exp});
        rx_rd = 1'b1;
        cyc(1);
        rx_rd = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    task automatic wait_avail(input string tag);
        int n = 0;
        while (!rx_avail && n < 3000) begin
            cyc(1);
            n++;
        end
        check(tag, {31'd0, rx_avail}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (tx_busy && n < 20000) begin
            cyc(1);
            n++;
        end
        check(tag, {31'd0, tx_busy}, 32'd0);
        cyc(20);
    endtask

    task automatic drive_frame(input logic [7:0] w, input logic stop);
        rx_drv = 1'b0;
        cyc(div);
        for (int i = 0; i < 8; i++) begin
            rx_drv = w[i];
            cyc(div);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^w) ^ par_flip;
        cyc(div);
`endif
        rx_drv = stop;
        cyc(div);
        rx_drv = 1'b1;
        cyc(div);
    endtask

    initial begin
        logic [7:0] w;
        logic       exp_bits [NB];
        int         n;

        rst      = 1'b1;
        clk_freq = 32'd50_000_000;
        div      = 434;
        tx_data  = '0;
        tx_wr    = 1'b0;
        rx_rd    = 1'b0;
        err_clr  = 1'b0;
        loop_en  = 1'b0;
        rx_drv   = 1'b1;
        cyc(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_full", {31'd0, tx_full}, 32'd0);
        check("rst_avail", {31'd0, rx_avail}, 32'd0);
        check("rst_int", {31'd0, int_req}, 32'd0);
        check("rst_flags", {29'd0, rx_overrun, frame_err, parity_err}, 32'd0);
        rst = 1'b0;
        cyc(2);

        // 1: line timing of 0x55 at divisor 434
        w = 8'h55;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            exp_bits[i+1] = w[i];
`ifdef UART_PARITY_EN
        exp_bits[9] = ^w;
`endif
        exp_bits[NB-1] = 1'b1;
        put(w);
        n = 0;
        while (tx && n < 2000) begin
            cyc(1);
            n++;
        end
        check("t1_start_seen", {31'd0, tx}, 32'd0);
        for (int i = 0; i < NB; i++) begin
            cyc(217);
            check($sformatf("t1_bit%0d", i), {31'd0, tx}, {31'd0, exp_bits[i]});
            if (i == NB - 1)
                check("t1_busy_in_stop", {31'd0, tx_busy}, 32'd1);
            cyc(217);
        end
        check("t1_busy_done", {31'd0, tx_busy}, 32'd0);
        check("t1_tx_idle", {31'd0, tx}, 32'd1);

        // 2: loopback, four words back to back at divisor 16
        clk_freq = 32'd1_843_200;
        div      = 16;
        loop_en  = 1'b1;
        cyc(5);
        put(8'h00);
        put(8'hFF);
        put(8'hA5);
        put(8'h3C);
        wait_avail("t2_first_word");
        cyc(1);
        check("t2_int_first", {31'd0, int_req}, 32'd1);
        wait_idle("t2_tx_done");
        check("t2_no_ovr", {31'd0, rx_overrun}, 32'd0);
        check("t2_no_fe", {31'd0, frame_err}, 32'd0);
        check("t2_no_pe", {31'd0, parity_err}, 32'd0);
        pop("t2_w0", 8'h00);
        pop("t2_w1", 8'hFF);
        pop("t2_w2", 8'hA5);
        check("t2_int_before_last", {31'd0, int_req}, 32'd1);
        pop("t2_w3", 8'h3C);
        cyc(1);
        check("t2_empty", {31'd0, rx_avail}, 32'd0);
        check("t2_int_clear", {31'd0, int_req}, 32'd0);

        // 3: five frames with no reads -> overrun
        for (int i = 0; i < 5; i++)
            put(8'h10 + 8'(i));
        wait_idle("t3_tx_done");
        check("t3_ovr", {31'd0, rx_overrun}, 32'd1);
        check("t3_int", {31'd0, int_req}, 32'd1);
        clr_err();
        check("t3_ovr_clr", {31'd0, rx_overrun}, 32'd0);
        for (int i = 0; i < 4; i++)
            pop($sformatf("t3_w%0d", i), 8'h10 + 8'(i));
        cyc(2);
        check("t3_empty", {31'd0, rx_avail}, 32'd0);
        check("t3_int_clear", {31'd0, int_req}, 32'd0);

        // 4: low stop bit on 0x81, then a short glitch at divisor 434
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        cyc(5);
        drive_frame(8'h81, 1'b0);
        cyc(5);
        check("t4_fe", {31'd0, frame_err}, 32'd1);
        pop("t4_w", 8'h81);
        clr_err();
        check("t4_fe_clr", {31'd0, frame_err}, 32'd0);
        clk_freq = 32'd50_000_000;
        div      = 434;
        cyc(5);
        rx_drv = 1'b0;
        cyc(100);
        rx_drv = 1'b1;
        cyc(5000);
        check("t4_glitch_none", {31'd0, rx_avail}, 32'd0);
        check("t4_glitch_fe", {31'd0, frame_err}, 32'd0);

        // 5: parity
        clk_freq = 32'd1_843_200;
        div      = 16;
        cyc(5);
`ifdef UART_PARITY_EN
        par_flip = 1'b1;
        drive_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        cyc(5);
        check("t5_pe", {31'd0, parity_err}, 32'd1);
`else
        drive_frame(8'h07, 1'b1);
        cyc(5);
        check("t5_pe_tied", {31'd0, parity_err}, 32'd0);
`endif
        pop("t5_w", 8'h07);
        check("t5_fe", {31'd0, frame_err}, 32'd0);
        clr_err();

        // 6: reset mid-TX and mid-RX
        loop_en = 1'b1;
        cyc(5);
        put(8'h11);
        wait_avail("t6_pre_word");
        wait_idle("t6_pre_idle");
        put(8'hC3);
        cyc(60);
        rst = 1'b1;
        #1;
        check("t6_tx_high", {31'd0, tx}, 32'd1);
        check("t6_rx_empty", {31'd0, rx_avail}, 32'd0);
        check("t6_busy", {31'd0, tx_busy}, 32'd0);
        check("t6_full", {31'd0, tx_full}, 32'd0);
        check("t6_int", {31'd0, int_req}, 32'd0);
        check("t6_flags", {29'd0, rx_overrun, frame_err, parity_err}, 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        put(8'h5A);
        wait_avail("t6_post_word");
        pop("t6_post", 8'h5A);
        check("t6_post_fe", {31'd0, frame_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
